// File: rtl/velocity_loop_pkg.sv
// Shared types and helpers for the multi-axis velocity loop.
// Contents:
//   state_t   - sequencer states of the time-multiplexed channel sweep
//   INTEG_W   - width of the per-channel saturating integrator
//   clamp_sym - symmetric saturation of a 32-bit signed value to +/-limit
package velocity_loop_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    ERR,
    MAC,
    WRITE
  } state_t;

  localparam int INTEG_W = 24;

  function automatic logic signed [31:0] clamp_sym(input logic signed [31:0] value,
                                                   input logic signed [31:0] limit);
    if (value > limit) begin
      return limit;
    end else if (value < -limit) begin
      return -limit;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/pi_datapath.sv
// Combinational P/I arithmetic shared by every channel of the velocity loop.
// Ports:
//   err        - ramped setpoint minus actual velocity (VEL_W+1 bits, signed)
//   kp, ki     - unsigned proportional / integral gains
//   integ      - current integrator of the channel being processed
//   block_pos  - previous sweep clamped high: refuse positive accumulation
//   block_neg  - previous sweep clamped low: refuse negative accumulation
//   p_reg      - proportional term registered during MAC
//   ramp_sp    - ramped setpoint, used directly in open-loop mode
//   open_loop  - bypass the PI terms and hold the integrator at zero
//   p_next     - kp*err
//   integ_next - integrator after this update (saturated, anti-windup aware)
//   gain       - clamped output gain
//   sat        - the output gain was clamped
module pi_datapath
  import velocity_loop_pkg::*;
#(
  parameter int VEL_W     = 16,
  parameter int GAIN_W    = 10,
  parameter int OUT_SHIFT = 4
) (
  input  logic signed [VEL_W:0]       err,
  input  logic        [7:0]           kp,
  input  logic        [7:0]           ki,
  input  logic signed [INTEG_W-1:0]   integ,
  input  logic                        block_pos,
  input  logic                        block_neg,
  input  logic signed [VEL_W+8:0]     p_reg,
  input  logic signed [VEL_W-1:0]     ramp_sp,
  input  logic                        open_loop,
  output logic signed [VEL_W+8:0]     p_next,
  output logic signed [INTEG_W-1:0]   integ_next,
  output logic signed [GAIN_W-1:0]    gain,
  output logic                        sat
);

  // An 8-bit unsigned gain times a VEL_W+1 bit error always fits VEL_W+9 signed bits.
  localparam int PW        = VEL_W + 9;
  localparam int GAIN_LIM  = (1 << (GAIN_W - 1)) - 1;
  localparam int INTEG_LIM = (1 << (INTEG_W - 1)) - 1;

  logic signed [PW-1:0] kp_ext, ki_ext, err_ext, i_inc;
  logic signed [31:0]   inc_ext, integ_ext, p_ext, ramp_ext;
  logic signed [31:0]   acc_sum, acc_clamped, out_raw, out_sel, out_clamped;
  logic                 inc_pos, inc_neg;

  always_comb begin
    kp_ext  = {{(PW - 8){1'b0}}, kp};
    ki_ext  = {{(PW - 8){1'b0}}, ki};
    err_ext = {{(PW - VEL_W - 1){err[VEL_W]}}, err};
    p_next  = kp_ext * err_ext;
    i_inc   = ki_ext * err_ext;

    inc_ext   = {{(32 - PW){i_inc[PW-1]}}, i_inc};
    integ_ext = {{(32 - INTEG_W){integ[INTEG_W-1]}}, integ};
    p_ext     = {{(32 - PW){p_reg[PW-1]}}, p_reg};
    ramp_ext  = {{(32 - VEL_W){ramp_sp[VEL_W-1]}}, ramp_sp};

    acc_sum     = integ_ext + inc_ext;
    acc_clamped = clamp_sym(acc_sum, INTEG_LIM);
    inc_pos     = !i_inc[PW-1] && (i_inc != '0);
    inc_neg     = i_inc[PW-1];

    // Anti-windup: keep the integrator where it is if it would push further
    // into the clamp that held on the previous sweep.
    if (open_loop) begin
      integ_next = '0;
    end else if ((block_pos && inc_pos) || (block_neg && inc_neg)) begin
      integ_next = integ;
    end else begin
      integ_next = acc_clamped[INTEG_W-1:0];
    end

    out_raw     = (p_ext + integ_ext) >>> OUT_SHIFT;
    out_sel     = open_loop ? (ramp_ext >>> (VEL_W - GAIN_W)) : out_raw;
    out_clamped = clamp_sym(out_sel, GAIN_LIM);
    gain        = out_clamped[GAIN_W-1:0];
    sat         = (out_clamped != out_sel);
  end

endmodule

// File: rtl/multi_axis_velocity_loop.sv
// Multi-channel PI velocity loop with setpoint ramping, sharing one datapath.
// Each update_strobe snapshots all inputs and sweeps the channels, spending
// one cycle per channel in each of RAMP, ERR, MAC and WRITE.
// Ports:
//   clk, reset       - rising-edge clock, asynchronous active-low reset
//   enable           - per-channel loop enable
//   open_loop        - per-channel PI bypass (output follows the ramp)
//   update_strobe    - control-rate tick that starts a sweep
//   desired_velocity - packed signed setpoints, channel k in slice k
//   actual_velocity  - packed signed measured velocities
//   kp, ki           - shared unsigned PI gains
//   accel_limit      - maximum setpoint change per update
//   output_gain      - packed signed registered gains
//   busy, done       - sweep in progress / one-cycle completion pulse
//   saturated        - per-channel clamp flag from the last sweep
//   overrun          - sticky: a strobe arrived while busy
module multi_axis_velocity_loop
  import velocity_loop_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int VEL_W     = 16,
  parameter int GAIN_W    = 10,
  parameter int OUT_SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         enable,
  input  logic [NUM_CH-1:0]         open_loop,
  input  logic                      update_strobe,
  input  logic [NUM_CH*VEL_W-1:0]   desired_velocity,
  input  logic [NUM_CH*VEL_W-1:0]   actual_velocity,
  input  logic [7:0]                kp,
  input  logic [7:0]                ki,
  input  logic [VEL_W-2:0]          accel_limit,
  output logic [NUM_CH*GAIN_W-1:0]  output_gain,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_CH-1:0]         saturated,
  output logic                      overrun
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t state_q, state_d;
  logic [CH_W-1:0] ch;
  logic            last_ch;

  logic [NUM_CH-1:0]        en_q, ol_q;
  logic [7:0]               kp_q, ki_q;
  logic [VEL_W-2:0]         acc_q;
  logic signed [VEL_W-1:0]  des_q   [NUM_CH];
  logic signed [VEL_W-1:0]  act_q   [NUM_CH];
  logic signed [VEL_W-1:0]  ramp_sp [NUM_CH];
  logic signed [INTEG_W-1:0] integ  [NUM_CH];
  logic signed [GAIN_W-1:0] gain_q  [NUM_CH];
  logic [NUM_CH-1:0]        sat_q;

  logic signed [VEL_W:0]    err_q, err_next;
  logic signed [VEL_W+8:0]  p_q, p_next;
  logic signed [INTEG_W-1:0] integ_next;
  logic signed [GAIN_W-1:0] gain_next;
  logic                     sat_next;

  logic signed [VEL_W:0]    ramp_diff, ramp_lim, ramp_step, ramp_sum;
  logic signed [VEL_W-1:0]  ramp_next;

  assign last_ch = (ch == CH_W'(NUM_CH - 1));
  assign busy    = (state_q != IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign output_gain[g*GAIN_W +: GAIN_W] = gain_q[g];
  end
  assign saturated = sat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (update_strobe) state_d = RAMP;
      RAMP:    state_d = ERR;
      ERR:     state_d = MAC;
      MAC:     state_d = WRITE;
      WRITE:   state_d = last_ch ? IDLE : RAMP;
      default: state_d = IDLE;
    endcase
  end

  // The ramp step is the setpoint gap clamped to +/-accel_limit; since it never
  // overshoots the target the sum stays inside the VEL_W range, even at -2^(VEL_W-1).
  always_comb begin
    ramp_diff = {des_q[ch][VEL_W-1], des_q[ch]} - {ramp_sp[ch][VEL_W-1], ramp_sp[ch]};
    ramp_lim  = {2'b00, acc_q};
    if (ramp_diff > ramp_lim) begin
      ramp_step = ramp_lim;
    end else if (ramp_diff < -ramp_lim) begin
      ramp_step = -ramp_lim;
    end else begin
      ramp_step = ramp_diff;
    end
    ramp_sum  = {ramp_sp[ch][VEL_W-1], ramp_sp[ch]} + ramp_step;
    ramp_next = ramp_sum[VEL_W-1:0];
    err_next  = {ramp_sp[ch][VEL_W-1], ramp_sp[ch]} - {act_q[ch][VEL_W-1], act_q[ch]};
  end

  pi_datapath #(
    .VEL_W     (VEL_W),
    .GAIN_W    (GAIN_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_pi (
    .err        (err_q),
    .kp         (kp_q),
    .ki         (ki_q),
    .integ      (integ[ch]),
    .block_pos  (sat_q[ch] && !gain_q[ch][GAIN_W-1]),
    .block_neg  (sat_q[ch] && gain_q[ch][GAIN_W-1]),
    .p_reg      (p_q),
    .ramp_sp    (ramp_sp[ch]),
    .open_loop  (ol_q[ch]),
    .p_next     (p_next),
    .integ_next (integ_next),
    .gain       (gain_next),
    .sat        (sat_next)
  );

  // A disabled channel tracks its measured velocity so it re-enables bumplessly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch      <= '0;
      done    <= 1'b0;
      overrun <= 1'b0;
      en_q    <= '0;
      ol_q    <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      acc_q   <= '0;
      err_q   <= '0;
      p_q     <= '0;
      sat_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        des_q[i]   <= '0;
        act_q[i]   <= '0;
        ramp_sp[i] <= '0;
        integ[i]   <= '0;
        gain_q[i]  <= '0;
      end
    end else begin
      done <= 1'b0;
      if (update_strobe && (state_q != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (update_strobe) begin
            ch    <= '0;
            en_q  <= enable;
            ol_q  <= open_loop;
            kp_q  <= kp;
            ki_q  <= ki;
            acc_q <= accel_limit;
            for (int i = 0; i < NUM_CH; i++) begin
              des_q[i] <= desired_velocity[i*VEL_W +: VEL_W];
              act_q[i] <= actual_velocity[i*VEL_W +: VEL_W];
            end
          end
        end
        RAMP:  ramp_sp[ch] <= en_q[ch] ? ramp_next : act_q[ch];
        ERR:   err_q <= err_next;
        MAC: begin
          p_q       <= p_next;
          integ[ch] <= en_q[ch] ? integ_next : '0;
        end
        WRITE: begin
          gain_q[ch] <= en_q[ch] ? gain_next : '0;
          sat_q[ch]  <= en_q[ch] && sat_next;
          if (last_ch) begin
            done <= 1'b1;
          end else begin
            ch <= ch + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_axis_velocity_loop.sv
// Self-checking bench for multi_axis_velocity_loop (NUM_CH=2 defaults).
// A behavioural per-channel model tracks ramp setpoint, integrator, gain and
// clamp flag with plain integer arithmetic; every sweep is compared to it.
module tb_multi_axis_velocity_loop;

  localparam int NUM_CH = 2;
  localparam int VEL_W  = 16;
  localparam int GAIN_W = 10;
  localparam longint GLIM = 511;
  localparam longint ILIM = 8388607;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH-1:0]        enable, open_loop;
  logic                     update_strobe;
  logic [NUM_CH*VEL_W-1:0]  desired_velocity, actual_velocity;
  logic [7:0]               kp, ki;
  logic [VEL_W-2:0]         accel_limit;
  logic [NUM_CH*GAIN_W-1:0] output_gain;
  logic                     busy, done, overrun;
  logic [NUM_CH-1:0]        saturated;

  int checks = 0;
  int failures = 0;

  longint s_des [NUM_CH];
  longint s_act [NUM_CH];
  bit     s_en  [NUM_CH];
  bit     s_ol  [NUM_CH];
  longint s_kp, s_ki, s_acc;

  longint m_ramp  [NUM_CH];
  longint m_integ [NUM_CH];
  longint m_gain  [NUM_CH];
  bit     m_sat   [NUM_CH];

  multi_axis_velocity_loop #(
    .NUM_CH    (NUM_CH),
    .VEL_W     (VEL_W),
    .GAIN_W    (GAIN_W),
    .OUT_SHIFT (4)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .open_loop        (open_loop),
    .update_strobe    (update_strobe),
    .desired_velocity (desired_velocity),
    .actual_velocity  (actual_velocity),
    .kp               (kp),
    .ki               (ki),
    .accel_limit      (accel_limit),
    .output_gain      (output_gain),
    .busy             (busy),
    .done             (done),
    .saturated        (saturated),
    .overrun          (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic signed [63:0] obs,
                              input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] en_v, input logic [1:0] ol_v,
                                input int d0, input int d1, input int a0, input int a1,
                                input int kp_v, input int ki_v, input int acc_v);
    enable           = en_v;
    open_loop        = ol_v;
    desired_velocity = {16'(d1), 16'(d0)};
    actual_velocity  = {16'(a1), 16'(a0)};
    kp               = 8'(kp_v);
    ki               = 8'(ki_v);
    accel_limit      = 15'(acc_v);
    s_en[0] = en_v[0]; s_en[1] = en_v[1];
    s_ol[0] = ol_v[0]; s_ol[1] = ol_v[1];
    s_des[0] = d0; s_des[1] = d1;
    s_act[0] = a0; s_act[1] = a1;
    s_kp = kp_v; s_ki = ki_v; s_acc = acc_v;
  endtask

  function automatic longint clampv(input longint v, input longint lim);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_ramp[c] = 0; m_integ[c] = 0; m_gain[c] = 0; m_sat[c] = 1'b0;
    end
  endtask

  task automatic model_sweep();
    longint delta, err, inc, v;
    bit blocked;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!s_en[c]) begin
        m_ramp[c] = s_act[c]; m_integ[c] = 0; m_gain[c] = 0; m_sat[c] = 1'b0;
      end else begin
        delta = clampv(s_des[c] - m_ramp[c], s_acc);
        m_ramp[c] = m_ramp[c] + delta;
        err = m_ramp[c] - s_act[c];
        if (s_ol[c]) begin
          m_integ[c] = 0;
          v = m_ramp[c] >>> 6;
        end else begin
          inc = s_ki * err;
          blocked = m_sat[c] && ((m_gain[c] > 0 && inc > 0) || (m_gain[c] < 0 && inc < 0));
          if (!blocked) m_integ[c] = clampv(m_integ[c] + inc, ILIM);
          v = (s_kp * err + m_integ[c]) >>> 4;
        end
        m_gain[c] = clampv(v, GLIM);
        m_sat[c]  = (m_gain[c] != v);
      end
    end
  endtask

  task automatic compare_outputs(input string tag);
    for (int c = 0; c < NUM_CH; c++) begin
      check_output($sformatf("%s_gain%0d", tag, c),
                   $signed(output_gain[c*GAIN_W +: GAIN_W]), m_gain[c]);
      check_output($sformatf("%s_sat%0d", tag, c), saturated[c], m_sat[c]);
    end
  endtask

  task automatic run_sweep(input string tag, input int inject_at);
    int done_at = 0;
    int busy_cnt = 0;
    @(negedge clk);
    update_strobe = 1'b1;
    for (int k = 1; k <= 30 && done_at == 0; k++) begin
      @(negedge clk);
      update_strobe = (k == inject_at);
      if (busy) busy_cnt++;
      if (done) done_at = k;
    end
    update_strobe = 1'b0;
    check_output({tag, "_done_latency"}, done_at, 9);
    check_output({tag, "_busy_cycles"}, busy_cnt, 8);
    model_sweep();
    compare_outputs(tag);
  endtask

  function automatic int rand_vel();
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 32767;
      2, 3:    return int'($urandom_range(0, 2000)) - 1000;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  function automatic int rand_acc();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 32767;
      2:       return int'($urandom_range(1, 500));
      default: return int'($urandom_range(0, 32767));
    endcase
  endfunction

  initial begin
    int done_cnt;
    reset = 1'b0;
    update_strobe = 1'b0;
    apply_stimulus(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_output("rst_gain", output_gain, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_sat", saturated, 0);
    check_output("rst_overrun", overrun, 0);
    reset = 1'b1;

    // Sweep timing with both channels enabled
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 100);
    run_sweep("timing", 0);

    // Open-loop ramp 100 per update toward +/-1000
    apply_stimulus(2'b11, 2'b11, 1000, -1000, 0, 0, 0, 0, 100);
    for (int i = 1; i <= 11; i++) begin
      run_sweep($sformatf("ramp%0d", i), 0);
      if (i == 1) check_output("ramp_first_gain0", $signed(output_gain[9:0]), 1);
      if (i == 10) begin
        check_output("ramp_end_gain0", $signed(output_gain[9:0]), 15);
        check_output("ramp_end_gain1", $signed(output_gain[19:10]), -16);
      end
    end

    // Proportional clamp, then small negative error (ramp frozen)
    apply_stimulus(2'b11, 2'b00, 0, 0, 0, 0, 10, 0, 0);
    run_sweep("pclamp", 0);
    check_output("pclamp_gain0", $signed(output_gain[9:0]), 511);
    check_output("pclamp_sat0", saturated[0], 1);
    apply_stimulus(2'b11, 2'b00, 0, 0, 1050, -950, 10, 0, 0);
    run_sweep("pneg", 0);
    check_output("pneg_gain0", $signed(output_gain[9:0]), -32);
    check_output("pneg_sat0", saturated[0], 0);

    // Strobe during a sweep is ignored and flagged
    check_output("overrun_before", overrun, 0);
    run_sweep("overrun", 3);
    check_output("overrun_after", overrun, 1);

    // Randomized sweeps
    for (int i = 0; i < 40; i++) begin
      logic [1:0] en_r, ol_r;
      en_r = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      ol_r = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      apply_stimulus(en_r, ol_r, rand_vel(), rand_vel(), rand_vel(), rand_vel(),
                     int'($urandom_range(0, 255)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20))
                                                 : int'($urandom_range(0, 255)),
                     rand_acc());
      run_sweep($sformatf("rand%0d", i), 0);
    end

    // Channel 1 disabled while channel 0 runs closed loop
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(2'b01, 2'b00, int'($urandom_range(0, 4000)) - 2000, 1234,
                     int'($urandom_range(0, 400)) - 200, 777, 3, 2, 300);
      run_sweep($sformatf("dis%0d", i), 0);
      check_output("dis_gain1", $signed(output_gain[19:10]), 0);
      check_output("dis_sat1", saturated[1], 0);
    end

    // Reset in the middle of a sweep
    apply_stimulus(2'b11, 2'b11, 20000, 20000, 0, 0, 0, 0, 32767);
    run_sweep("prereset", 0);
    @(negedge clk);
    update_strobe = 1'b1;
    @(negedge clk);
    update_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("midrst_gain", output_gain, 0);
    check_output("midrst_sat", saturated, 0);
    check_output("midrst_busy", busy, 0);
    check_output("midrst_overrun", overrun, 0);
    done_cnt = 0;
    @(negedge clk);
    if (done) done_cnt++;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check_output("midrst_no_done", done_cnt, 0);
    model_reset();
    apply_stimulus(2'b11, 2'b00, 500, -500, 100, -100, 20, 5, 32767);
    run_sweep("postreset", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_axis_velocity_loop.md
MULTI_AXIS_VELOCITY_LOOP -- requirements
Module: multi_axis_velocity_loop

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of motor channels (1..8).
REQ-002 SHALL have parameter VEL_W, default 16, signed velocity width.
REQ-003 SHALL have parameter GAIN_W, default 10, signed output gain width.
REQ-004 SHALL have parameter OUT_SHIFT, default 4, arithmetic right shift applied to the P+I sum.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port enable, input, NUM_CH, per-channel loop enable.
REQ-008 SHALL have port open_loop, input, NUM_CH, per-channel mode: 1 bypasses the PI loop.
REQ-009 SHALL have port update_strobe, input, 1, one-cycle control-rate tick.
REQ-010 SHALL have port desired_velocity, input, NUM_CH*VEL_W, signed setpoints; channel k is in slice k.
REQ-011 SHALL have port actual_velocity, input, NUM_CH*VEL_W, signed filtered velocities.
REQ-012 SHALL have port kp, input, 8, unsigned proportional gain shared by all channels.
REQ-013 SHALL have port ki, input, 8, unsigned integral gain shared by all channels.
REQ-014 SHALL have port accel_limit, input, VEL_W-1, unsigned maximum setpoint change per update.
REQ-015 SHALL have port output_gain, output, NUM_CH*GAIN_W, signed registered gains for the commutation stage.
REQ-016 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-017 SHALL have port done, output, 1, one-cycle pulse when a sweep completes.
REQ-018 SHALL have port saturated, output, NUM_CH, per-channel flag that the output clamped on the last sweep.
REQ-019 SHALL have port overrun, output, 1, sticky flag for an update_strobe received while busy.

Function
REQ-020 SHALL use a single time-multiplexed datapath; the FSM states are IDLE, RAMP, ERR, MAC, WRITE.
REQ-021 IDLE + update_strobe SHALL snapshot all inputs, set ch=0, and go to RAMP; other IDLE cycles SHALL hold.
REQ-022 SHALL spend one cycle per state per channel, RAMP->ERR->MAC->WRITE; WRITE SHALL go to RAMP (ch+1) or, at ch=NUM_CH-1, to IDLE.
REQ-023 SHALL pulse done in the cycle after the last WRITE; strobe-to-done latency SHALL be exactly 4*NUM_CH+1 cycles.
REQ-024 busy SHALL be high from the cycle after the accepted strobe until the cycle done is asserted, exclusive.
REQ-025 update_strobe while busy SHALL be ignored and SHALL set overrun; only reset SHALL clear overrun.
REQ-026 RAMP SHALL update ramp_sp[ch] by (desired - ramp_sp) clamped to ±accel_limit; accel_limit=0 SHALL freeze ramp_sp.
REQ-027 ERR SHALL compute err = ramp_sp - actual at VEL_W+1 bits, without overflow.
REQ-028 MAC SHALL form P = kp*err and update a 24-bit saturating integrator by ki*err.
REQ-029 The integrator SHALL NOT accumulate in the direction of an output clamp that held on the previous sweep (anti-windup).
REQ-030 WRITE SHALL compute (P+I)>>>OUT_SHIFT, clamp it to ±(2^(GAIN_W-1)-1), register it to output_gain[ch], and set saturated[ch] if clamping occurred.
REQ-031 open_loop[ch]=1 SHALL write ramp_sp>>>(VEL_W-GAIN_W), clamped, and SHALL hold the integrator at 0.
REQ-032 enable[ch]=0 SHALL give output_gain[ch]=0, integrator=0, ramp_sp=actual, saturated[ch]=0, evaluated at that channel's slot.
REQ-033 -2^(VEL_W-1) inputs SHALL NOT overflow the error or ramp arithmetic.

Reset
REQ-034 Reset asserted SHALL immediately give state IDLE, and zero all outputs, ramp_sp, and integrators.
REQ-035 Reset mid-sweep SHALL abort the sweep with no done pulse; release SHALL resume in IDLE.

Structure
REQ-036 velocity_loop_pkg SHALL hold the state enum, the 24-bit integrator width constant, and the saturation helper function.
REQ-037 The P/I arithmetic and clamping SHALL be one sub-module, pi_datapath; the FSM and channel register files SHALL stay in the top.

Verification
REQ-038 NUM_CH=2, one strobe: done exactly 9 cycles after the strobe; busy high for 8 cycles.
REQ-039 desired=1000, actual=0, accel_limit=100, kp=0/ki=0, open_loop: ramp_sp steps 100, 200, ... and reaches 1000 on the 10th update.
REQ-040 kp=10, ki=0, err=1000, OUT_SHIFT=4: output_gain=511 and saturated=1; with err=-50: output_gain=-32.
REQ-041 Strobe asserted during a sweep: the strobe is ignored, overrun=1, and the sweep still completes in 9 cycles.
REQ-042 Reset pulsed mid-sweep: outputs become 0 at once and no done pulse occurs.
REQ-043 enable[1]=0 with channel 0 active: output_gain[1]=0, and channel 0 behaves identically to a NUM_CH=1 run.
